// File: rtl/keyboard_encoder26_if.sv
// Letter handshake between the keyboard front end and the rotor/plugboard core.
interface keyboard_encoder26_if;
  logic [4:0] LETTER;
  logic       VALID;
  logic       READY;

  // Keyboard side: offers letters.
  modport master (output LETTER, output VALID, input READY);
  // Core side: accepts letters.
  modport slave  (input LETTER, input VALID, output READY);
endinterface

// File: rtl/keyboard_encoder26.sv
// Keyboard front end: synchronises and debounces 26 one-per-letter key lines,
// accepts a single pressed key and offers its 5-bit index once per press.
module keyboard_encoder26 #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic                        CLOCK_50,
  input  logic                        RESETN,
  input  logic [25:0]                 KEYS,
  keyboard_encoder26_if.master        bus,
  output logic                        MULTI_ERR,
  output logic                        BUSY
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    OFFER        = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // More than one bit set: clearing the lowest set bit leaves something behind.
  function automatic logic is_multi(input logic [25:0] v);
    return |(v & (v - 26'd1));
  endfunction

  function automatic logic is_onehot(input logic [25:0] v);
    return (v != 26'd0) && !is_multi(v);
  endfunction

  // Index of the set bit; only meaningful when v is one-hot.
  function automatic logic [4:0] onehot_index(input logic [25:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 26; i++) begin
      if (v[i]) begin
        idx = 5'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [25:0] onehot_of(input logic [4:0] idx);
    return 26'd1 << idx;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [25:0]       sync1_r, sk_r;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [4:0]        cand_r, cand_nxt_s;
  logic [4:0]        letter_r, letter_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic              multi_r, busy_r;

  // Next-state and output decisions, all taken from the synchronised keys.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    cand_nxt_s   = cand_r;
    letter_nxt_s = letter_r;
    valid_nxt_s  = valid_r;
    case (state_r)
      IDLE: begin
        if (is_onehot(sk_r)) begin
          cand_nxt_s  = onehot_index(sk_r);
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = DEBOUNCE;
        end else begin
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      end
      DEBOUNCE: begin
        if (sk_r == onehot_of(cand_r)) begin
          if (cnt_r == CNT_MAX) begin
            state_nxt_s  = OFFER;
            valid_nxt_s  = 1'b1;
            letter_nxt_s = cand_r;
            cnt_nxt_s    = {CNT_W{1'b0}};
          end else begin
            cnt_nxt_s    = cnt_r + CNT_ONE;
          end
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      end
      OFFER: begin
        // The letter is committed: key changes cannot withdraw it.
        if (bus.READY) begin
          valid_nxt_s = 1'b0;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = WAIT_RELEASE;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (sk_r == 26'd0) begin
          if (cnt_r == CNT_MAX) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_nxt_s = {CNT_W{1'b0}};
        end
      end
      default: begin
        state_nxt_s = IDLE;
        valid_nxt_s = 1'b0;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, synchroniser and registered outputs; reset clears everything.
  always_ff @(posedge CLOCK_50) begin
    if (!RESETN) begin
      state_r  <= IDLE;
      sync1_r  <= 26'd0;
      sk_r     <= 26'd0;
      cnt_r    <= {CNT_W{1'b0}};
      cand_r   <= 5'd0;
      letter_r <= 5'd0;
      valid_r  <= 1'b0;
      multi_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      sync1_r  <= KEYS;
      sk_r     <= sync1_r;
      cnt_r    <= cnt_nxt_s;
      cand_r   <= cand_nxt_s;
      letter_r <= letter_nxt_s;
      valid_r  <= valid_nxt_s;
      multi_r  <= is_multi(sk_r);
      busy_r   <= (state_nxt_s != IDLE);
    end
  end

  assign bus.LETTER = letter_r;
  assign bus.VALID  = valid_r;
  assign MULTI_ERR  = multi_r;
  assign BUSY       = busy_r;

endmodule

// File: tb/tb_keyboard_encoder26.sv
// Scoreboard bench for keyboard_encoder26: stimulus pushes expected letters,
// a monitor pops them on each handshake transfer.
module tb_keyboard_encoder26;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [25:0] keys = 26'd0;
  logic        multi_err, busy;

  keyboard_encoder26_if kb_if();

  keyboard_encoder26 #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .CLOCK_50 (clk),
    .RESETN   (rst_n),
    .KEYS     (keys),
    .bus      (kb_if),
    .MULTI_ERR(multi_err),
    .BUSY     (busy)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [4:0] exp_q[$];
  bit         rnd_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) kb_if.READY = 1'($urandom_range(0, 1));
  endtask

  // Counts VALID cycles over n edges; first is the 0-based edge after which VALID first rose.
  task automatic measure(input int n, output int first, output int highs);
    first = -1;
    highs = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (kb_if.VALID) begin
        if (first < 0) first = i;
        highs++;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    keys = 26'd0;
    while ((busy || kb_if.VALID) && n < 300) begin
      tick();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
    repeat (2) tick();
  endtask

  // Monitor: pops the scoreboard on each transfer, checks offers stay put under backpressure.
  initial begin
    logic       prev_hold;
    logic [4:0] prev_letter;
    logic [4:0] e;
    prev_hold = 1'b0;
    prev_letter = 5'd0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("valid_hold", {31'd0, kb_if.VALID}, 32'd1);
          check("letter_hold", {27'd0, kb_if.LETTER}, {27'd0, prev_letter});
        end
        if (kb_if.VALID && kb_if.READY) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL extra_transfer: got letter %0d expected no transfer", kb_if.LETTER);
          end else begin
            e = exp_q.pop_front();
            check("letter", {27'd0, kb_if.LETTER}, {27'd0, e});
          end
        end
        prev_hold = kb_if.VALID && !kb_if.READY;
        prev_letter = kb_if.LETTER;
      end
    end
  end

  // Reference for MULTI_ERR: popcount of the key vector sampled two edges earlier.
  logic [25:0] h1 = 26'd0, h2 = 26'd0, h3 = 26'd0;
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n !== 1'b1) begin
        h1 = 26'd0; h2 = 26'd0; h3 = 26'd0;
      end else begin
        h3 = h2; h2 = h1; h1 = keys;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1)
        check("multi_err", {31'd0, multi_err}, ($countones(h3) > 1) ? 32'd1 : 32'd0);
    end
  end

  initial begin
    int first, highs, a, b;
    kb_if.READY = 1'b0;
    keys = 26'h3FFFFFF;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'd0, kb_if.VALID}, 32'd0);
    check("rst_letter", {27'd0, kb_if.LETTER}, 32'd0);
    check("rst_multi", {31'd0, multi_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    keys = 26'd0;
    repeat (3) tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Single press with READY high: latency and one transfer per press.
    kb_if.READY = 1'b1;
    exp_q.push_back(5'd7);
    keys = 26'd1 << 7;
    measure(30, first, highs);
    check("lat_first", first, 32'd6);
    check("lat_highs", highs, 32'd1);
    keys = 26'd0;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (j == 4) check("release_busy_hi", {31'd0, busy}, 32'd1);
      if (j == 5) check("release_busy_lo", {31'd0, busy}, 32'd0);
    end

    // Backpressure: offer survives key release.
    kb_if.READY = 1'b0;
    exp_q.push_back(5'd25);
    keys = 26'd1 << 25;
    repeat (10) tick();
    keys = 26'd0;
    repeat (6) tick();
    check("bp_valid", {31'd0, kb_if.VALID}, 32'd1);
    check("bp_letter", {27'd0, kb_if.LETTER}, 32'd25);
    kb_if.READY = 1'b1;
    tick();
    check("bp_after", {31'd0, kb_if.VALID}, 32'd0);
    wait_idle("bp_idle");

    // Reset while offering drops the offer; held key is re-offered.
    kb_if.READY = 1'b0;
    exp_q.push_back(5'd12);
    keys = 26'd1 << 12;
    repeat (10) tick();
    check("ro_valid", {31'd0, kb_if.VALID}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("ro_rst_valid", {31'd0, kb_if.VALID}, 32'd0);
    check("ro_rst_letter", {27'd0, kb_if.LETTER}, 32'd0);
    rst_n = 1'b1;
    kb_if.READY = 1'b1;
    measure(20, first, highs);
    check("ro_first", first, 32'd6);
    check("ro_highs", highs, 32'd1);
    wait_idle("ro_idle");

    // Randomised episodes: bounced presses, multi-key presses, random READY.
    rnd_ready = 1'b1;
    for (int ep = 0; ep < 40; ep++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 25);
        b = (a + $urandom_range(1, 25)) % 26;
        keys = (26'd1 << a) | (26'd1 << b);
        repeat ($urandom_range(4, 12)) tick();
        check("multi_idle", {31'd0, busy}, 32'd0);
        if ($urandom_range(0, 1) == 1) begin
          keys = 26'd1 << a;
          exp_q.push_back(5'(a));
          repeat (10) tick();
        end
        wait_idle("multi_done");
      end else begin
        a = $urandom_range(0, 25);
        for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
          keys = 26'd1 << a;
          repeat ($urandom_range(1, 3)) tick();
          keys = 26'd0;
          repeat ($urandom_range(1, 3)) tick();
        end
        keys = 26'd1 << a;
        exp_q.push_back(5'(a));
        repeat ($urandom_range(8, 16)) tick();
        wait_idle("single_done");
      end
    end
    rnd_ready = 1'b0;
    kb_if.READY = 1'b1;
    wait_idle("final_idle");
    check("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keyboard_encoder26.md
Name: keyboard_encoder26

Overview:
Keyboard-side front end for the Enigma datapath, and the inverse of the letter-index-to-one-hot decoder. It samples 26 raw one-per-letter key lines and debounces them. It accepts exactly one pressed key, encodes it to a 5-bit letter index (A=0 … Z=25), and offers it to the rotor/plugboard core over a valid/ready handshake. Each physical press yields exactly one transfer; there is no auto-repeat.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a press or release is accepted (minimum 1; board build uses 500000).
CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
RESETN  input  1  synchronous active-low reset
KEYS  input  26  raw asynchronous key lines, active-high, bit i = letter i
READY  input  1  core can accept a letter this cycle
LETTER  output  5  encoded letter index, valid while VALID=1
VALID  output  1  letter offered to core
MULTI_ERR  output  1  registered level, high while synchronised KEYS has more than one bit set
BUSY  output  1  high whenever state is not IDLE

Behaviour:
- Reset (RESETN=0 at a rising edge): state IDLE; VALID=0; LETTER=0; MULTI_ERR=0; BUSY=0; counter=0; both sync stages=0. Reset has priority over every other event.
- Synchroniser: KEYS passes through a 2-flop synchroniser (sk). All decisions use sk only.
- Encoding: index of the single set bit of sk. Values 26–31 are never produced on LETTER.
- MULTI_ERR: registered from sk (popcount>1), so it reflects KEYS after the 3rd edge.
- IDLE:
  - sk zero or multi-hot: stay in IDLE.
  - sk exactly one-hot: capture index into cand, counter=0, go to DEBOUNCE.
- DEBOUNCE:
  - sk equal to one-hot(cand) and counter < DEBOUNCE_CYCLES-1: counter++.
  - sk equal to one-hot(cand) and counter == DEBOUNCE_CYCLES-1: go to OFFER; VALID=1, LETTER=cand (registered).
  - sk differs in any bit: go to IDLE and clear counter; re-evaluation starts the next cycle.
- OFFER:
  - VALID held at 1 and LETTER held constant until a cycle with VALID=1 and READY=1 (the transfer).
  - On the transfer edge: VALID=0, counter=0, go to WAIT_RELEASE.
  - Releasing or changing keys in OFFER does not cancel the offer; the letter is committed.
- WAIT_RELEASE:
  - sk==0: counter++. When counter reaches DEBOUNCE_CYCLES-1 with sk==0, go to IDLE.
  - Any set bit: counter=0. Holding a key therefore never produces a second letter.
- Latency: with KEYS stable from just before edge 0 and READY=1, VALID is high after edge DEBOUNCE_CYCLES+2, i.e. the (DEBOUNCE_CYCLES+3)-th edge. With READY=1, VALID is high for exactly one cycle.
- READY is ignored outside OFFER.
- Reset mid-operation:
  - Any outstanding offer is dropped with no transfer.
  - A key still held after reset is treated as a new press and re-offered after full latency.

Test Plan:
1. Reset: RESETN=0 for 2 edges with KEYS=26'h3FFFFFF -> VALID=0, LETTER=0, MULTI_ERR=0, BUSY=0; state IDLE after release.
2. Single press, DEBOUNCE_CYCLES=4, READY=1: KEYS=1<<7 held 30 cycles -> VALID=1 for exactly one cycle after the 7th edge, LETTER=7, no further VALID while held. Release -> BUSY drops after release debounce (4 zero cycles in WAIT_RELEASE).
3. Backpressure: READY=0, KEYS=1<<25 for 10 cycles then released -> VALID stays 1, LETTER=25 unchanged throughout. Then READY=1 -> one transfer, VALID=0 the following cycle, no second VALID.
4. Bounce: bit 3 toggled every 2 cycles for 12 cycles, then held -> no VALID during toggling; exactly one VALID, LETTER=3, 7 edges after the final stable edge.
5. Multi-key: KEYS bits 0 and 1 -> MULTI_ERR=1 after 3 edges, no VALID. Drop bit 1 -> MULTI_ERR=0 after 3 edges, then a single VALID with LETTER=0 after full latency.
6. Reset during OFFER: READY=0, VALID=1, LETTER=12, then RESETN=0 for 1 edge -> VALID=0, LETTER=0. Key still held after reset -> new VALID with LETTER=12 7 edges after RESETN returns high.
